// File: rtl/single_port_ram_pipe_pkg.sv
// -----------------------------------------------------------------------------
// single_port_ram_pkg
// Shared definitions for the single-port pipelined RAM:
//   - write-mode selectors (NO_CHANGE / WRITE_FIRST / READ_FIRST)
//   - INIT/READY state encoding for the clear sequencer
//   - byte_merge(): applies byte-lane enables to a stored word
// -----------------------------------------------------------------------------
package single_port_ram_pkg;

    // Write-mode selectors for the WR_MODE parameter.
    localparam int unsigned NO_CHANGE   = 0;
    localparam int unsigned WRITE_FIRST = 1;
    localparam int unsigned READ_FIRST  = 2;

    // Clear-sequencer state encoding.
    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_READY = 1'b1;

    // Widest word byte_merge() handles; callers size-cast in and out.
    localparam int unsigned MAX_DATA_W = 256;

    // Replace every byte of old_word whose enable is set with the matching
    // byte of new_word; bytes with a clear enable are kept.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0]   old_word,
        input logic [MAX_DATA_W-1:0]   new_word,
        input logic [MAX_DATA_W/8-1:0] be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(MAX_DATA_W / 8); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/single_port_ram_pipe_if.sv
// -----------------------------------------------------------------------------
// single_port_ram_pipe_if
// Request/response bundle of the single-port RAM.
//   master: drives ena, wea, be, din, addr; observes dout, read_valid, ready, drop
//   slave : the RAM side (directions reversed)
// -----------------------------------------------------------------------------
interface single_port_ram_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic                  ena;
    logic                  wea;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     din;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     dout;
    logic                  read_valid;
    logic                  ready;
    logic                  drop;

    modport master (
        output ena, wea, be, din, addr,
        input  dout, read_valid, ready, drop
    );

    modport slave (
        input  ena, wea, be, din, addr,
        output dout, read_valid, ready, drop
    );
endinterface

// File: rtl/single_port_ram_pipe_init_ctrl.sv
// -----------------------------------------------------------------------------
// ram_init_ctrl
// INIT/READY sequencer for the single-port RAM. After reset it walks the
// clear address from 0 to DEPTH-1 (one zero-write per cycle), then parks in
// READY until the next reset.
//   clk, rst     : clock, async active-high reset
//   i_ena        : access request from the bus (used only for drop)
//   o_ready      : 1 once the clear sweep has finished
//   o_drop       : registered pulse for a request seen while not ready
//   o_clr_we     : zero-write strobe for the array
//   o_clr_addr   : address of the current zero-write
// -----------------------------------------------------------------------------
module ram_init_ctrl
    import single_port_ram_pkg::*;
#(
    parameter int unsigned ADDR_W       = 4,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ena,
    output logic              o_ready,
    output logic              o_drop,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    logic              r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR_ON_RST ? ST_INIT : ST_READY;
            r_clr_addr <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= i_ena & (r_state != ST_READY);
            if (r_state == ST_INIT) begin
                r_clr_addr <= r_clr_addr + 1'b1;
                // Last word is zeroed on this edge; accept requests from the next.
                if (r_clr_addr == {ADDR_W{1'b1}}) begin
                    r_state <= ST_READY;
                end
            end
        end
    end

    assign o_ready    = (r_state == ST_READY);
    assign o_clr_we   = (r_state == ST_INIT);
    assign o_clr_addr = r_clr_addr;
    assign o_drop     = r_drop;

endmodule

// File: rtl/single_port_ram_pipe.sv
// -----------------------------------------------------------------------------
// single_port_ram_pipe
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write response, optional output register and a post-reset
// sequential zero-fill.
//   clk, rst : clock, async active-high reset
//   io_bus   : slave side of single_port_ram_pipe_if
//              (ena, wea, be, din, addr in; dout, read_valid, ready, drop out)
// DATA_W must be a multiple of 8 and no wider than MAX_DATA_W.
// -----------------------------------------------------------------------------
module single_port_ram_pipe
    import single_port_ram_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 4,
    parameter bit          OUT_REG      = 1'b1,
    parameter int unsigned WR_MODE      = NO_CHANGE,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    single_port_ram_pipe_if.slave io_bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_drop;
    logic              w_accept;
    logic              w_wr;
    logic              w_resp;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_resp_data;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;

    ram_init_ctrl #(
        .ADDR_W       (ADDR_W),
        .CLEAR_ON_RST (CLEAR_ON_RST)
    ) u_init_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_ena      (io_bus.ena),
        .o_ready    (w_ready),
        .o_drop     (w_drop),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_accept = io_bus.ena & w_ready;
    assign w_wr     = w_accept & io_bus.wea;
    // Writes only produce a response when the mode returns a word.
    assign w_resp   = w_accept & (~io_bus.wea | (WR_MODE != NO_CHANGE));
    assign w_old    = r_mem[io_bus.addr];
    assign w_merged = DATA_W'(byte_merge(MAX_DATA_W'(w_old), MAX_DATA_W'(io_bus.din),
                                         (MAX_DATA_W/8)'(io_bus.be)));
    assign w_resp_data = (io_bus.wea && (WR_MODE == WRITE_FIRST)) ? w_merged : w_old;

    // Array has no reset; the clear sweep (if enabled) zeroes it instead.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr) begin
            r_mem[io_bus.addr] <= w_merged;
        end
    end

    // Stage 1: captures the word at the accepting edge; holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_resp;
            if (w_resp) begin
                r_s1_data <= w_resp_data;
            end
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic              r_s2_valid;
        logic [DATA_W-1:0] r_s2_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign io_bus.dout       = r_s2_data;
        assign io_bus.read_valid = r_s2_valid;
    end else begin : g_no_out_reg
        assign io_bus.dout       = r_s1_data;
        assign io_bus.read_valid = r_s1_valid;
    end

    assign io_bus.ready = w_ready;
    assign io_bus.drop  = w_drop;

endmodule
